// File: rtl/dbus_pkg.sv
// Shared types and constants for the data-bus initiator.
// Alignment checking is built only when DBUS_ALIGN_CHECK_EN is defined.
package dbus_pkg;

    localparam int BIT_WIDTH = 32;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_e;

    // SIZE=11 behaves as a word, so it needs word alignment too
    function automatic logic misaligned(
        input logic [1:0] sz,
        input logic [1:0] lsb
    );
        logic half_bad;
        logic word_bad;
        half_bad = (sz == SZ_HALF) && lsb[0];
        word_bad = ((sz == SZ_WORD) || (sz == 2'b11))
                   && (lsb != 2'b00);
        return half_bad || word_bad;
    endfunction

endpackage

// File: rtl/dbus_master_if.sv
// MEM-stage request/response and data-bus control signals.
// DDT stays a plain inout port of the master so tri-state resolves on a net.
interface dbus_master_if #(
    parameter int W = 32
) ();

    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [1:0]   req_size;
    logic         req_unsigned;
    logic [W-1:0] req_addr;
    logic [W-1:0] req_wdata;
    logic         rsp_valid;
    logic [W-1:0] rsp_rdata;
    logic         rsp_err;
    logic [W-1:0] DAD;
    logic         MREQ;
    logic         WRITE;
    logic [1:0]   SIZE;
    logic         ACKD_n;

    modport master (
        input  req_valid, req_write, req_size,
        input  req_unsigned, req_addr, req_wdata,
        input  ACKD_n,
        output req_ready, rsp_valid, rsp_rdata,
        output rsp_err, DAD, MREQ, WRITE, SIZE
    );

    modport slave (
        output req_valid, req_write, req_size,
        output req_unsigned, req_addr, req_wdata,
        output ACKD_n,
        input  req_ready, rsp_valid, rsp_rdata,
        input  rsp_err, DAD, MREQ, WRITE, SIZE
    );

endinterface

// File: rtl/dbus_lane_align.sv
// Store lane packing and load extraction with sign/zero extension.
// Sub-word data is always carried on the low lanes of DDT.
module dbus_lane_align #(
    parameter int BIT_WIDTH = dbus_pkg::BIT_WIDTH
) (
    input  logic [1:0]           size_i,
    input  logic                 uns_i,
    input  logic [BIT_WIDTH-1:0] wdata_i,
    input  logic [BIT_WIDTH-1:0] rbus_i,
    output logic [BIT_WIDTH-1:0] wlane_o,
    output logic [BIT_WIDTH-1:0] rdata_o
);
    import dbus_pkg::*;

    logic hsign;
    logic bsign;

    assign hsign = !uns_i && rbus_i[15];
    assign bsign = !uns_i && rbus_i[7];

    always_comb begin
        wlane_o = wdata_i;
        rdata_o = rbus_i;
        case (size_i)
            SZ_HALF: begin
                wlane_o = {{(BIT_WIDTH-16){1'b0}}, wdata_i[15:0]};
                rdata_o = {{(BIT_WIDTH-16){hsign}}, rbus_i[15:0]};
            end
            SZ_BYTE: begin
                wlane_o = {{(BIT_WIDTH-8){1'b0}}, wdata_i[7:0]};
                rdata_o = {{(BIT_WIDTH-8){bsign}}, rbus_i[7:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dbus_master.sv
// Data-bus initiator: one load/store per transaction, held until ACKD_n.
// Optional DBUS_ALIGN_CHECK_EN rejects misaligned half/word requests.
module dbus_master #(
    parameter int BIT_WIDTH      = dbus_pkg::BIT_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    dbus_master_if.master        bus,
    inout  wire  [BIT_WIDTH-1:0] DDT
);
    import dbus_pkg::*;

    localparam int TW = (TIMEOUT_CYCLES > 1)
                        ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST =
        TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_e               state_q;
    logic                 mreq_q;
    logic                 write_q;
    logic                 uns_q;
    logic [1:0]           size_q;
    logic [BIT_WIDTH-1:0] addr_q;
    logic [BIT_WIDTH-1:0] wdata_q;
    logic [BIT_WIDTH-1:0] rdata_q;
    logic                 rsp_valid_q;
    logic                 rsp_err_q;
    logic [TW-1:0]        timer_q;

    logic                 accept;
    logic                 ack;
    logic                 tmo;
    logic                 bad;
    logic [BIT_WIDTH-1:0] wlane;
    logic [BIT_WIDTH-1:0] rext;

    assign accept = bus.req_valid && (state_q == ST_IDLE);
    assign ack    = !bus.ACKD_n;
    assign tmo    = (TIMEOUT_CYCLES != 0) && (timer_q == T_LAST);

`ifdef DBUS_ALIGN_CHECK_EN
    assign bad = misaligned(bus.req_size, bus.req_addr[1:0]);
`else
    assign bad = 1'b0;
`endif

    dbus_lane_align #(
        .BIT_WIDTH(BIT_WIDTH)
    ) u_align (
        .size_i  (size_q),
        .uns_i   (uns_q),
        .wdata_i (wdata_q),
        .rbus_i  (DDT),
        .wlane_o (wlane),
        .rdata_o (rext)
    );

    assign DDT = write_q ? wlane : {BIT_WIDTH{1'bz}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mreq_q      <= 1'b0;
            write_q     <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            timer_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept && bad) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rdata_q     <= '0;
                    end else if (accept) begin
                        state_q <= ST_BUS;
                        mreq_q  <= 1'b1;
                        write_q <= bus.req_write;
                        uns_q   <= bus.req_unsigned;
                        size_q  <= bus.req_size;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        timer_q <= '0;
                    end
                end
                ST_BUS: begin
                    // ack has priority over a timeout on the same edge
                    if (ack || tmo) begin
                        state_q     <= ST_IDLE;
                        mreq_q      <= 1'b0;
                        write_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= !ack;
                        rdata_q     <= (ack && !write_q) ? rext : '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.DAD       = addr_q;
    assign bus.MREQ      = mreq_q;
    assign bus.WRITE     = write_q;
    assign bus.SIZE      = size_q;

endmodule

// File: tb/tb_dbus_master.sv
// Directed plus randomized bench for dbus_master with a behavioural model.
// Build with DBUS_ALIGN_CHECK_EN to also exercise misaligned rejection.
module tb_dbus_master;

    localparam int          TMO   = 8;
    localparam logic [31:0] PROBE = 32'h5A5A_C3C3;

    logic clk;
    logic rst;

    dbus_master_if #(.W(32)) bus ();

    wire  [31:0] ddt;
    logic        tb_drv;
    logic [31:0] tb_val;

    assign ddt = tb_drv ? tb_val : 32'bz;

    dbus_master #(
        .BIT_WIDTH      (32),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .DDT (ddt)
    );

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: sub-word values live in the low bytes
    function automatic logic [31:0] m_lane(
        input logic [1:0]  sz,
        input logic [31:0] d
    );
        longint v;
        v = d;
        if (sz == 2'b01) v = v % 65536;
        if (sz == 2'b10) v = v % 256;
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_load(
        input logic [1:0]  sz,
        input bit          uns,
        input logic [31:0] d
    );
        longint v;
        v = d;
        if (sz == 2'b01) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v - 65536;
        end else if (sz == 2'b10) begin
            v = v % 256;
            if (!uns && v >= 128) v = v - 256;
        end
        return v[31:0];
    endfunction

    // Called in an idle cycle just after the falling edge.
    // nack = BUS cycle whose closing edge sees ack; 0 = never.
    task automatic txn(
        input bit          wr,
        input logic [1:0]  sz,
        input bit          uns,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [31:0] bdata,
        input int          nack
    );
        bit          tmo;
        int          n;
        logic [31:0] lane;
        logic [31:0] exp_rd;
        tmo    = (nack == 0) || (nack > TMO);
        n      = tmo ? TMO : nack;
        lane   = m_lane(sz, wdata);
        exp_rd = (tmo || wr) ? 32'h0 : m_load(sz, uns, bdata);

        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        if (wr) tb_drv = 1'b0;
        #1;
        chk("req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = ~addr;
        bus.req_wdata = ~wdata;
        bus.req_size  = ~sz;
        bus.req_write = ~wr;
        for (int c = 1; c <= n; c++) begin
            if (!wr) begin
                tb_drv = 1'b1;
                tb_val = bdata;
            end
            bus.ACKD_n = (c == nack) ? 1'b0 : 1'b1;
            #1;
            chk("bus_mreq", 32'(bus.MREQ), 32'd1);
            chk("bus_dad", bus.DAD, addr);
            chk("bus_write", 32'(bus.WRITE), 32'(wr));
            chk("bus_size", 32'(bus.SIZE), 32'(sz));
            chk("bus_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("bus_ready", 32'(bus.req_ready), 32'd0);
            if (wr) chk("store_lane", ddt, lane);
            @(negedge clk);
        end
        bus.ACKD_n = 1'b1;
        tb_drv     = 1'b1;
        tb_val     = PROBE;
        #1;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_err", 32'(bus.rsp_err), 32'(tmo));
        chk("rsp_rdata", bus.rsp_rdata, exp_rd);
        chk("rsp_mreq", 32'(bus.MREQ), 32'd0);
        chk("rsp_write", 32'(bus.WRITE), 32'd0);
        chk("rsp_ready", 32'(bus.req_ready), 32'd1);
        chk("rsp_ddt_free", ddt, PROBE);
    endtask

    initial begin
        bit          wr;
        logic [1:0]  sz;
        bit          uns;
        logic [31:0] addr;

        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.ACKD_n       = 1'b1;
        tb_drv           = 1'b1;
        tb_val           = PROBE;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_mreq", 32'(bus.MREQ), 32'd0);
        chk("rst_write", 32'(bus.WRITE), 32'd0);
        chk("rst_size", 32'(bus.SIZE), 32'd0);
        chk("rst_dad", bus.DAD, 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_ddt_free", ddt, PROBE);
        @(negedge clk);
        rst = 1'b0;

        // ack while idle must not start anything
        bus.ACKD_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("idle_ack_mreq", 32'(bus.MREQ), 32'd0);
            chk("idle_ack_rsp", 32'(bus.rsp_valid), 32'd0);
            chk("idle_ack_ready", 32'(bus.req_ready), 32'd1);
        end
        bus.ACKD_n = 1'b1;
        @(negedge clk);

        txn(0, 2'b00, 0, 32'h0800_0000, 32'h0, 32'hDEAD_BEEF, 1);
        txn(0, 2'b10, 0, 32'h0800_0013, 32'h0, 32'h1234_5680, 1);
        txn(0, 2'b10, 1, 32'h0800_0013, 32'h0, 32'h1234_5680, 2);
        txn(0, 2'b01, 0, 32'h0800_0010, 32'h0, 32'h7777_8001, 1);
        txn(0, 2'b01, 1, 32'h0800_0010, 32'h0, 32'h7777_8001, 1);
        txn(1, 2'b10, 0, 32'hF000_0000, 32'hAABB_CC41, 32'h0, 3);
        txn(1, 2'b01, 0, 32'h0800_0020, 32'h1357_9BDF, 32'h0, 1);
        txn(1, 2'b00, 0, 32'h0800_0024, 32'h0246_8ACE, 32'h0, 2);
        txn(0, 2'b11, 0, 32'h0800_0028, 32'h0, 32'h8765_4321, 1);
        txn(0, 2'b00, 0, 32'h0800_002C, 32'h0, 32'h1111_2222, 0);
        txn(0, 2'b00, 0, 32'h0800_0030, 32'h0, 32'h3333_4444, TMO);
        txn(1, 2'b00, 0, 32'h0800_0034, 32'hCAFE_F00D, 32'h0, 0);

        for (int i = 0; i < 40; i++) begin
            wr   = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            uns  = 1'($urandom_range(0, 1));
            addr = $urandom;
`ifdef DBUS_ALIGN_CHECK_EN
            addr[1:0] = 2'b00;
`endif
            txn(wr, sz, uns, addr, $urandom, $urandom,
                int'($urandom_range(0, 9)));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                #1;
                chk("gap_rsp", 32'(bus.rsp_valid), 32'd0);
                chk("gap_mreq", 32'(bus.MREQ), 32'd0);
            end
        end

        // reset in the middle of a store
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'b00;
        bus.req_addr  = 32'h0800_0040;
        bus.req_wdata = 32'h0F0F_0F0F;
        tb_drv        = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk("mid_mreq_up", 32'(bus.MREQ), 32'd1);
        chk("mid_ddt_drv", ddt, 32'h0F0F_0F0F);
        @(negedge clk);
        rst    = 1'b1;
        tb_drv = 1'b1;
        tb_val = PROBE;
        #1;
        chk("mid_rst_mreq", 32'(bus.MREQ), 32'd0);
        chk("mid_rst_write", 32'(bus.WRITE), 32'd0);
        chk("mid_rst_ddt", ddt, PROBE);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("post_rst_rsp", 32'(bus.rsp_valid), 32'd0);
            chk("post_rst_mreq", 32'(bus.MREQ), 32'd0);
        end

`ifdef DBUS_ALIGN_CHECK_EN
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_size  = 2'b00;
        bus.req_addr  = 32'h0800_0002;
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk("mis_rsp", 32'(bus.rsp_valid), 32'd1);
        chk("mis_err", 32'(bus.rsp_err), 32'd1);
        chk("mis_mreq", 32'(bus.MREQ), 32'd0);
        chk("mis_rdata", bus.rsp_rdata, 32'd0);
        @(negedge clk);
        #1;
        chk("mis_mreq2", 32'(bus.MREQ), 32'd0);
        chk("mis_rsp2", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        txn(0, 2'b01, 1, 32'h0800_0006, 32'h0, 32'h0000_9ABC, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
